qb_pixel_loader: RTL and testbench
==================================

// Module: qb_pixel_loader
// PURPOSE
//  Sequences pixel uploads from the SPI register bank into the shared image RAM.
//  - Each Trigger pulse (SPI write of Blue) pushes the current {Red,Green,Blue} into a small FIFO.
//  - The FSM drains the FIFO into RAM via a req/ack handshake; the RAM is shared with the display reader.
//  - Per-image pixel pointer auto-increments; progress/error flags feed the SPI Status register.
// PARAMETERS
//  PIX_BITS    10  pixel-index width; image holds 2**PIX_BITS pixels
//  IMG_BITS    3   image-select width, taken from ImgNum[IMG_BITS-1:0]
//  FIFO_DEPTH  4   pixel FIFO entries; power of two, >=2
// PORTS
//  theClock     in   1                  system clock
//  theReset     in   1                  asynchronous reset, active-high
//  Load_start   in   1                  1-cycle pulse: begin loading image ImgNum
//  Trigger      in   1                  1-cycle pulse: Red/Green/Blue valid, push pixel
//  Red          in   8                  pixel red component
//  Green        in   8                  pixel green component
//  Blue         in   8                  pixel blue component
//  ImgNum       in   8                  target image; low IMG_BITS used at Load_start
//  Mem_ack      in   1                  RAM grant/write-complete; sampled only while Mem_req=1
//  Mem_req      out  1                  RAM write request
//  Mem_addr     out  IMG_BITS+PIX_BITS  {img, ptr}
//  Mem_wdata    out  24                 {R,G,B} of FIFO head
//  Pixel_count  out  PIX_BITS           pixels written in current image (= ptr)
//  Status       out  8                  [0]busy [1]done [2]overflow [3]fifo_full [7:4]=0
// BEHAVIOUR
//  Clock and reset
//  - Reset (async, active-high) values: Mem_req=0, Mem_addr=0, Mem_wdata=0, Pixel_count=0, Status=0.
//  - Reset also clears img=0, ptr=0, FIFO empty, FSM=S_Idle.
//  FIFO
//  - Trigger with FIFO not full and state!=S_Done: push {Red,Green,Blue} at that edge.
//  - Trigger with FIFO full or in S_Done: pixel dropped; overflow set (sticky).
//  - Push and pop in the same cycle is legal: count unchanged, FIFO order kept.
//  - Write and read pointers wrap modulo FIFO_DEPTH.
//  FSM states: S_Idle, S_Req, S_Done
//  - S_Idle: FIFO non-empty -> S_Req. Mem_req=1 and Mem_addr/Mem_wdata are registered on entry.
//  - S_Req: Mem_req, Mem_addr and Mem_wdata held stable until Mem_ack=1.
//    On ack: pop FIFO, ptr+1, Mem_req=0 next cycle.
//    If ptr was 2**PIX_BITS-1 -> S_Done, ptr wraps to 0 and Pixel_count reads 0.
//    Otherwise -> S_Idle.
//  - Every write includes at least one S_Idle cycle (max 1 write per 2 cycles). Mem_ack may arrive in the same cycle Mem_req first rises.
//  - S_Done: done=1, Mem_req=0. Exits only on Load_start.
//  Load_start (highest priority, any state)
//  - img <= ImgNum[IMG_BITS-1:0]; ptr, FIFO, done and overflow cleared; Mem_req=0 next cycle; -> S_Idle.
//  - An in-flight request is abandoned; a Mem_ack in that cycle is ignored.
//  - Trigger in the same cycle: applied after the clear, so the pixel becomes FIFO entry 0.
//  Latency
//  - Trigger at edge N -> Mem_req=1 at edge N+2 when idle and the FIFO was empty.
//  Status (combinational from registers)
//  - busy = (state==S_Req) | FIFO non-empty.
//  - fifo_full = FIFO count == FIFO_DEPTH.
//  - A mid-operation reset is identical to power-up reset.
// TESTING
//  1. Load_start, ImgNum=5; Trigger RGB=0x112233, Mem_ack tied 1
//     -> Mem_req at N+2, Mem_addr={3'd5,10'd0}, Mem_wdata=0x112233, Pixel_count=1.
//  2. Mem_ack held 0; 5 Triggers (FIFO_DEPTH=4)
//     -> 4 stored, 5th dropped, Status=0x0D; then ack -> 4 writes in push order.
//  3. 1024 Triggers with prompt acks
//     -> last write at addr {img,0x3FF}; S_Done; Status=0x02; Pixel_count=0; further Trigger sets overflow, no Mem_req.
//  4. Load_start asserted while S_Req and Mem_ack=1 in the same cycle
//     -> no pop, ptr=0, Mem_req=0 next cycle, Status=0x00.
//  5. Load_start and Trigger in the same cycle -> first write to ptr 0 with that pixel.
//  6. Assert theReset asynchronously mid-write -> all outputs 0 immediately, no clock edge required.

Source files
------------

// File: rtl/qb_pixel_loader.sv
// Pixel upload sequencer: buffers SPI-triggered RGB pixels in a small FIFO and
// drains them into the shared image RAM through a req/ack handshake.
module qb_pixel_loader #(
  parameter int PIX_BITS   = 10,
  parameter int IMG_BITS   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         theClock,
  input  logic                         theReset,
  input  logic                         Load_start,
  input  logic                         Trigger,
  input  logic [7:0]                   Red,
  input  logic [7:0]                   Green,
  input  logic [7:0]                   Blue,
  input  logic [7:0]                   ImgNum,
  input  logic                         Mem_ack,
  output logic                         Mem_req,
  output logic [IMG_BITS+PIX_BITS-1:0] Mem_addr,
  output logic [23:0]                  Mem_wdata,
  output logic [PIX_BITS-1:0]          Pixel_count,
  output logic [7:0]                   Status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {S_Idle, S_Req, S_Done} state_t;

  state_t              state, state_nxt;
  logic [IMG_BITS-1:0] img;
  logic [PIX_BITS-1:0] ptr;
  logic [23:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                overflow;
  logic                fifo_full, fifo_empty, push, pop, drop;
  logic                req_nxt, load_out;

  assign fifo_full  = (count == DEPTH);
  assign fifo_empty = (count == '0);

  // Load_start clears the FIFO first, so a coincident Trigger always fits.
  assign push = Trigger && (Load_start || (!fifo_full && state != S_Done));
  assign drop = Trigger && !Load_start && (fifo_full || state == S_Done);
  assign pop  = (state == S_Req) && Mem_ack && !Load_start;

  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      state     <= S_Idle;
      Mem_req   <= 1'b0;
      Mem_addr  <= '0;
      Mem_wdata <= '0;
      img       <= '0;
      ptr       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state   <= state_nxt;
      Mem_req <= req_nxt;
      if (load_out) begin
        Mem_addr  <= {img, ptr};
        Mem_wdata <= fifo_mem[rd_ptr];
      end
      if (Load_start) begin
        img      <= ImgNum[IMG_BITS-1:0];
        ptr      <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
        wr_ptr   <= push ? AW'(1) : '0;
        count    <= push ? (AW+1)'(1) : '0;
      end else begin
        if (pop) begin
          ptr    <= ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (drop) overflow <= 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge theClock) begin
    if (push) fifo_mem[Load_start ? '0 : wr_ptr] <= {Red, Green, Blue};
  end

  always_comb begin
    state_nxt = state;
    if (Load_start) state_nxt = S_Idle;
    else begin
      case (state)
        S_Idle:  if (!fifo_empty) state_nxt = S_Req;
        S_Req:   if (Mem_ack) state_nxt = (&ptr) ? S_Done : S_Idle;
        default: state_nxt = state;
      endcase
    end
  end

  // Request registers are captured only on the Idle->Req transition and then held.
  always_comb begin
    req_nxt  = (state_nxt == S_Req);
    load_out = (state == S_Idle) && (state_nxt == S_Req);
  end

  assign Pixel_count = ptr;
  assign Status = {4'b0000, fifo_full, overflow, state == S_Done,
                   (state == S_Req) || !fifo_empty};

endmodule

// File: tb/tb_qb_pixel_loader.sv
// Directed self-checking bench for qb_pixel_loader; inputs are driven 1 time unit
// after a rising edge, so a Trigger "at edge N" is sampled by the DUT at edge N+1.
module tb_qb_pixel_loader;
  logic        theClock, theReset, Load_start, Trigger, Mem_ack, Mem_req;
  logic [7:0]  Red, Green, Blue, ImgNum, Status;
  logic [12:0] Mem_addr;
  logic [23:0] Mem_wdata;
  logic [9:0]  Pixel_count;

  int checks = 0;
  int failures = 0;
  logic [12:0] addr_q[$];
  logic [23:0] data_q[$];

  qb_pixel_loader dut (
    .theClock(theClock), .theReset(theReset), .Load_start(Load_start),
    .Trigger(Trigger), .Red(Red), .Green(Green), .Blue(Blue), .ImgNum(ImgNum),
    .Mem_ack(Mem_ack), .Mem_req(Mem_req), .Mem_addr(Mem_addr),
    .Mem_wdata(Mem_wdata), .Pixel_count(Pixel_count), .Status(Status)
  );

  initial theClock = 1'b0;
  always #5 theClock = ~theClock;

  // A completed write is any edge with req and ack both high, unless Load_start aborts it.
  always @(posedge theClock)
    if (!theReset && Mem_req && Mem_ack && !Load_start) begin
      addr_q.push_back(Mem_addr);
      data_q.push_back(Mem_wdata);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge theClock);
    #1;
  endtask

  task automatic trig(input logic [23:0] rgb);
    {Red, Green, Blue} = rgb;
    Trigger = 1'b1;
    tick();
    Trigger = 1'b0;
  endtask

  task automatic load(input logic [7:0] n);
    ImgNum = n;
    Load_start = 1'b1;
    tick();
    Load_start = 1'b0;
  endtask

  initial begin
    int bad;
    theReset = 1'b1; Load_start = 0; Trigger = 0; Mem_ack = 0;
    Red = 0; Green = 0; Blue = 0; ImgNum = 0;
    #12;
    chk("rst_req", Mem_req, 0);
    chk("rst_addr", Mem_addr, 0);
    chk("rst_wdata", Mem_wdata, 0);
    chk("rst_pc", Pixel_count, 0);
    chk("rst_status", Status, 0);
    @(posedge theClock); #1;
    theReset = 1'b0;

    // 1: latency and first write address
    load(8'd5);
    Mem_ack = 1'b1;
    trig(24'h112233);
    chk("t1_req_n1", Mem_req, 0);
    tick();
    chk("t1_req_n2", Mem_req, 1);
    chk("t1_addr", Mem_addr, 13'h1400);
    chk("t1_wdata", Mem_wdata, 24'h112233);
    tick();
    chk("t1_req_drop", Mem_req, 0);
    chk("t1_pc", Pixel_count, 1);
    chk("t1_status", Status, 8'h00);

    // 2: fill FIFO with ack withheld, fifth pixel dropped
    Mem_ack = 1'b0;
    addr_q.delete(); data_q.delete();
    for (int i = 0; i < 5; i++) trig(24'hA00000 + 24'(i));
    tick(2);
    chk("t2_status", Status, 8'h0D);
    chk("t2_req_held", Mem_req, 1);
    chk("t2_addr_held", Mem_addr, 13'h1401);
    chk("t2_wdata_held", Mem_wdata, 24'hA00000);
    Mem_ack = 1'b1;
    tick(12);
    chk("t2_nwr", addr_q.size(), 4);
    bad = 0;
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      if (addr_q[i] !== 13'h1401 + 13'(i) || data_q[i] !== 24'hA00000 + 24'(i)) bad++;
    chk("t2_order", bad, 0);
    chk("t2_pc", Pixel_count, 5);
    chk("t2_status_after", Status, 8'h04);

    // 3: full image of 1024 pixels, ends in done
    load(8'd2);
    addr_q.delete(); data_q.delete();
    for (int i = 0; i < 1024; i++) begin
      trig(24'(i));
      tick(3);
    end
    tick(4);
    chk("t3_nwr", addr_q.size(), 1024);
    bad = 0;
    for (int i = 0; i < 1024 && i < addr_q.size(); i++)
      if (addr_q[i] !== {3'd2, 10'(i)} || data_q[i] !== 24'(i)) bad++;
    chk("t3_seq", bad, 0);
    if (addr_q.size() > 0) chk("t3_last_addr", addr_q[addr_q.size()-1], 13'h0BFF);
    chk("t3_status", Status, 8'h02);
    chk("t3_pc", Pixel_count, 0);
    trig(24'h777777);
    chk("t3_ovf", Status, 8'h06);
    tick(3);
    chk("t3_no_req", Mem_req, 0);
    chk("t3_nwr_after", addr_q.size(), 1024);

    // 4: Load_start coincides with ack while requesting
    Mem_ack = 1'b0;
    load(8'd1);
    addr_q.delete(); data_q.delete();
    trig(24'h123456);
    tick();
    chk("t4_req", Mem_req, 1);
    ImgNum = 8'd1; Load_start = 1'b1; Mem_ack = 1'b1;
    tick();
    Load_start = 1'b0; Mem_ack = 1'b0;
    chk("t4_req_clr", Mem_req, 0);
    chk("t4_pc", Pixel_count, 0);
    chk("t4_status", Status, 8'h00);
    Mem_ack = 1'b1;
    tick(3);
    chk("t4_nwr", addr_q.size(), 0);
    chk("t4_status2", Status, 8'h00);

    // 5: Load_start with Trigger discards old FIFO, keeps the new pixel
    Mem_ack = 1'b0;
    trig(24'h111111);
    trig(24'h222222);
    ImgNum = 8'd3; Load_start = 1'b1;
    {Red, Green, Blue} = 24'hABCDEF; Trigger = 1'b1;
    tick();
    Load_start = 1'b0; Trigger = 1'b0;
    addr_q.delete(); data_q.delete();
    Mem_ack = 1'b1;
    tick(8);
    chk("t5_nwr", addr_q.size(), 1);
    if (addr_q.size() > 0) begin
      chk("t5_addr", addr_q[0], 13'h0C00);
      chk("t5_data", data_q[0], 24'hABCDEF);
    end
    chk("t5_pc", Pixel_count, 1);

    // 6: asynchronous reset mid-request
    Mem_ack = 1'b0;
    trig(24'h445566);
    tick();
    chk("t6_req", Mem_req, 1);
    chk("t6_addr", Mem_addr, 13'h0C01);
    #2 theReset = 1'b1;
    #1;
    chk("t6_req0", Mem_req, 0);
    chk("t6_addr0", Mem_addr, 0);
    chk("t6_wdata0", Mem_wdata, 0);
    chk("t6_pc0", Pixel_count, 0);
    chk("t6_status0", Status, 0);
    tick();
    theReset = 1'b0;
    tick(2);
    chk("t6_idle", Mem_req, 0);
    chk("t6_status1", Status, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
